// File: rtl/explosion_pkg.sv
// Shared constants and types for the ship explosion animator.
// Optional retrigger is enabled by the EXPLOSION_RETRIGGER_EN macro.
package explosion_pkg;
  localparam int SPRITE_SIZE = 32;
  localparam int NUM_FRAMES = 4;
  localparam int FRAME_HOLD = 6;
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
  localparam int PIPE_LAT = 3;

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;
endpackage

// File: rtl/explosion_frame_seq.sv
// Play/idle sequencer: frame tick, hold/frame counters, position latch.
// EXPLOSION_RETRIGGER_EN lets a trigger during PLAY restart the run.
module explosion_frame_seq #(
  parameter int NUM_FRAMES = explosion_pkg::NUM_FRAMES,
  parameter int FRAME_HOLD = explosion_pkg::FRAME_HOLD,
  parameter int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                trigger,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  output logic [FW-1:0]       frame,
  output logic                busy,
  output logic                done,
  output explosion_pkg::pos_t pos
);
  import explosion_pkg::*;

  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(FRAME_HOLD - 1);

  state_t        state;
  logic          frame_clk_q;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          last_tick;
  logic          retrig;

  assign tick = frame_clk & ~frame_clk_q;
  assign last_tick = tick && (hold_cnt == LAST_HOLD)
                     && (frame == LAST_FRAME);
  assign busy = (state == PLAY);

`ifdef EXPLOSION_RETRIGGER_EN
  assign retrig = trigger;
`else
  assign retrig = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      frame_clk_q <= 1'b0;
      hold_cnt <= '0;
      frame <= '0;
      pos <= '0;
      done <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state <= PLAY;
            pos <= '{x: pos_x, y: pos_y};
            frame <= '0;
            hold_cnt <= '0;
          end
        end
        PLAY: begin
          // The final tick wins over a coincident trigger.
          if (last_tick) begin
            state <= IDLE;
            done <= 1'b1;
            hold_cnt <= '0;
          end else if (retrig) begin
            pos <= '{x: pos_x, y: pos_y};
            frame <= '0;
            hold_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt == LAST_HOLD) begin
              hold_cnt <= '0;
              frame <= frame + 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/spaceship_explosion_animator.sv
// Explosion sprite animator: ROM addressing, box test, 3-cycle pipeline.
// EXPLOSION_RETRIGGER_EN enables restart on trigger while playing.
module spaceship_explosion_animator #(
  parameter int SPRITE_SIZE = explosion_pkg::SPRITE_SIZE,
  parameter int NUM_FRAMES = explosion_pkg::NUM_FRAMES,
  parameter int FRAME_HOLD = explosion_pkg::FRAME_HOLD,
  parameter int ADDR_W = $clog2(NUM_FRAMES * SPRITE_SIZE * SPRITE_SIZE)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              trigger,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        explosion_index,
  output logic              explosion_on,
  output logic              busy,
  output logic              done
);
  import explosion_pkg::*;

  localparam int SW = $clog2(SPRITE_SIZE);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [FW-1:0]     frame;
  pos_t              pos;
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;
  logic              qual_d1;
  logic              qual_d2;

  explosion_frame_seq #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_HOLD(FRAME_HOLD),
    .FW(FW)
  ) u_seq (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .trigger(trigger),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .frame(frame),
    .busy(busy),
    .done(done),
    .pos(pos)
  );

  // 11-bit offsets: a negative offset sets the top bit, so no wrap-around.
  assign dx = {1'b0, DrawX} - {1'b0, pos.x};
  assign dy = {1'b0, DrawY} - {1'b0, pos.y};
  assign in_box = (dx[10:SW] == '0) && (dy[10:SW] == '0);
  assign addr_next = ADDR_W'({frame, dy[SW-1:0], dx[SW-1:0]});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      qual_d1 <= 1'b0;
      qual_d2 <= 1'b0;
      explosion_index <= TRANSPARENT_IDX;
      explosion_on <= 1'b0;
    end else begin
      rom_addr <= (busy && in_box) ? addr_next : '0;
      qual_d1 <= busy && in_box;
      qual_d2 <= qual_d1;
      explosion_index <= qual_d2 ? rom_data : TRANSPARENT_IDX;
      explosion_on <= qual_d2 && (rom_data != TRANSPARENT_IDX);
    end
  end
endmodule

// File: tb/tb_spaceship_explosion_animator.sv
// Directed bench for spaceship_explosion_animator with a sync ROM model.
// Build with EXPLOSION_RETRIGGER_EN to exercise the retrigger variant.
module tb_spaceship_explosion_animator;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        trigger = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic [3:0]  explosion_index;
  logic        explosion_on;
  logic        busy;
  logic        done;

  logic [3:0] mem [4096];
  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         addr;
    bit         in;
  } vec_t;
  vec_t vecs [8];

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= mem[rom_addr];

  spaceship_explosion_animator dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .trigger(trigger),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .explosion_index(explosion_index),
    .explosion_on(explosion_on),
    .busy(busy),
    .done(done)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_pulse();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step(3);
  endtask

  function automatic int exp_idx(input int addr, input bit in);
    return in ? int'(mem[addr]) : 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cur_px;
    int n;
    int ei;
    int done_seen;
    bit retrig_done;

    for (int i = 0; i < 4096; i++) mem[i] = 4'((i % 15) + 1);
    mem[2373] = 4'h9;
    mem[2372] = 4'h0;
    mem[324] = 4'h0;

    vecs[0] = '{10'd105, 10'd60, 325, 1'b1};
    vecs[1] = '{10'd104, 10'd60, 324, 1'b1};
    vecs[2] = '{10'd100, 10'd50, 0, 1'b1};
    vecs[3] = '{10'd131, 10'd81, 1023, 1'b1};
    vecs[4] = '{10'd132, 10'd60, 0, 1'b0};
    vecs[5] = '{10'd99, 10'd60, 0, 1'b0};
    vecs[6] = '{10'd105, 10'd82, 0, 1'b0};
    vecs[7] = '{10'd105, 10'd49, 0, 1'b0};

    step(2);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst index", explosion_index, 0);
    chk("rst on", explosion_on, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    Reset = 1'b0;
    DrawX = 10'd5;
    DrawY = 10'd5;
    tick_pulse();
    tick_pulse();
    step(2);
    chk("idle busy", busy, 0);
    chk("idle rom_addr", rom_addr, 0);
    chk("idle on", explosion_on, 0);

    pos_x = 10'd100;
    pos_y = 10'd50;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("start busy", busy, 1);
    chk("start done", done, 0);

    for (int i = 0; i < 8; i++) begin
      pix(vecs[i].x, vecs[i].y);
      ei = exp_idx(vecs[i].addr, vecs[i].in);
      chk($sformatf("vec%0d addr", i), rom_addr, vecs[i].addr);
      chk($sformatf("vec%0d index", i), explosion_index, ei);
      chk($sformatf("vec%0d on", i), explosion_on, int'(ei != 0));
    end

    cur_px = 100;
    n = 0;
    retrig_done = 1'b0;
    pix(cur_px + 5, 60);
    while (n < 23) begin
      tick_pulse();
      n++;
      chk($sformatf("tick%0d addr", n), rom_addr, (n / 6) * 1024 + 325);
      chk($sformatf("tick%0d busy", n), busy, 1);
      chk($sformatf("tick%0d done", n), done, 0);
      if (n == 6 && !retrig_done) begin
        retrig_done = 1'b1;
`ifdef EXPLOSION_RETRIGGER_EN
        cur_px = 101;
        n = 0;
`endif
        DrawX = 10'(cur_px + 5);
        pos_x = 10'd101;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("retrig done a", done, 0);
        step();
        chk("retrig addr", rom_addr, (n / 6) * 1024 + 325);
        chk("retrig busy", busy, 1);
        chk("retrig done b", done, 0);
      end
      if (n == 12) begin
        pix(cur_px + 32, 60);
        chk("f2 out addr", rom_addr, 0);
        chk("f2 out on", explosion_on, 0);
        DrawX = 10'(cur_px + 5);
        step();
        chk("f2 t1 addr", rom_addr, 2373);
        step();
        chk("f2 t2 index", explosion_index, 0);
        step();
        chk("f2 t3 index", explosion_index, 9);
        chk("f2 t3 on", explosion_on, 1);
        pix(cur_px + 4, 60);
        chk("f2 transp addr", rom_addr, 2372);
        chk("f2 transp index", explosion_index, 0);
        chk("f2 transp on", explosion_on, 0);
        pix(cur_px + 5, 60);
      end
    end

    pos_x = 10'd1020;
    pos_y = 10'd0;
    frame_clk = 1'b1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    frame_clk = 1'b0;
    chk("final done", done, 1);
    chk("final busy", busy, 0);
    step();
    chk("after done", done, 0);
    chk("after busy", busy, 0);
    step(2);
    chk("after rom_addr", rom_addr, 0);

    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("nowrap busy", busy, 1);
    pix(3, 5);
    chk("nowrap addr", rom_addr, 0);
    chk("nowrap on", explosion_on, 0);
    pix(1023, 5);
    chk("edge addr", rom_addr, 163);
    chk("edge index", explosion_index, 14);
    chk("edge on", explosion_on, 1);

    #3;
    Reset = 1'b1;
    #1;
    chk("midrst on", explosion_on, 0);
    chk("midrst index", explosion_index, 0);
    chk("midrst addr", rom_addr, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    step(2);
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      frame_clk = i[0];
      step();
      if (done) done_seen++;
    end
    chk("post rst done", done_seen, 0);
    chk("post rst busy", busy, 0);
    chk("post rst on", explosion_on, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
